i2c_master_ctrl: RTL and testbench
==================================

Name: i2c_master_ctrl

Overview:
- Single-transaction I2C master controller. Sequences START, 7-bit address + R/W, ACK, one data byte, ACK/NACK and STOP on the bus shared with the I2C slave block.
- Derives SCL from the system clock and drives SDA open-drain. Output SDA_OE=1 pulls the line low; the pad/top level builds the open-drain driver.
- Host side uses a REQ/BUSY/DONE handshake. Register-level configuration and test sequencing of the slave go through this block instead of testbench include scripts.

Parameters:
- CLK_DIV, 4, system clocks per SCL quarter-period; legal range 3..255.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RSTN  in  1  synchronous active-low reset.
- REQ  in  1  transaction request; sampled only in IDLE.
- RW  in  1  0 = write, 1 = read; latched on acceptance.
- ADDR  in  7  slave address; latched on acceptance.
- WDATA  in  8  write byte; latched on acceptance.
- SDA_IN  in  1  bus SDA level; asynchronous, 2-flop synchronised internally.
- SCL  out  1  bus clock (push-pull; no clock stretching).
- SDA_OE  out  1  1 = drive SDA low, 0 = release.
- RDATA  out  8  byte received by the last successful read.
- BUSY  out  1  high from acceptance until DONE.
- DONE  out  1  one-cycle pulse at end of transaction.
- ACK_ERR  out  1  slave NACKed the address or write data.

Behaviour:
- Reset (RSTN=0 at a CLK edge, any state, including mid-transfer):
  - Next cycle: SCL=1, SDA_OE=0, BUSY=0, DONE=0, ACK_ERR=0, RDATA=0.
  - State=IDLE; divider, quarter and bit counters cleared.
  - No STOP is generated.
- Quarter tick: divider counts 0..CLK_DIV-1 and asserts the tick on terminal count. Each bit slot is 4 quarters, Q0..Q3.
  - Q0, Q1: SCL=0.
  - Q2, Q3: SCL=1.
  - SDA_OE changes only at the start of Q0.
  - SDA_IN (synchronised) is sampled on the tick ending Q2.
- States: IDLE, START, ADDR, AACK, WR, WACK, RD, MACK, STOP.
- IDLE:
  - SCL=1, SDA_OE=0.
  - REQ=1: latch RW/ADDR/WDATA, BUSY=1, clear ACK_ERR and divider, go to START.
  - REQ while BUSY is ignored (no queueing).
- START: SCL=1 throughout. SDA released for Q0–Q1, SDA_OE=1 for Q2–Q3 (falling SDA while SCL high), then ADDR.
- ADDR: 8 bit slots, MSB first: ADDR[6]..ADDR[0], then RW. SDA_OE = ~bit.
- AACK: SDA_OE=0; sample.
  - Sample=1: ACK_ERR=1, go STOP.
  - Else RW=0 → WR; RW=1 → RD.
- WR: 8 slots, WDATA MSB first.
- WACK: SDA_OE=0; sample=1 → ACK_ERR=1. Always go STOP.
- RD: SDA_OE=0; 8 slots. Each sample shifts into an internal shift register, MSB first.
- MACK: SDA_OE=0 (master NACK, single byte). RDATA updated with the shift register at the end of MACK. Go STOP.
- STOP:
  - Q0–Q1: SCL=0, SDA_OE=1.
  - Q2: SCL=1, SDA_OE=1.
  - Q3: SCL=1, SDA_OE=0 (rising SDA while SCL high).
  - On the final tick: DONE=1 for one cycle, BUSY=0 the same cycle, state=IDLE.
- Latency: a full transaction is 80 quarters (START 4 + 36 + 36 + STOP 4). With CLK_DIV=4, DONE occurs 320 cycles after the REQ acceptance edge. An address NACK shortens this to 44 quarters.
- RDATA holds its value across write transactions and failed reads; it is updated only at MACK.
- ACK_ERR holds until the next accepted REQ or reset.
- REQ held high continuously: a new transaction is accepted the cycle after DONE.

Test Plan:
- Write to ADDR=0x2A, WDATA=0x5C, ACKing slave model, CLK_DIV=4:
  - Bus shows START, bits 0x54, ACK, 0x5C, ACK, STOP.
  - DONE exactly 320 cycles after acceptance; ACK_ERR=0.
- Read from ADDR=0x2A, slave returns 0xA5:
  - Address byte 0x55; master NACK observed.
  - RDATA=0xA5 at DONE; ACK_ERR=0.
- Address NACK (SDA_IN held high):
  - ACK_ERR=1; STOP follows AACK directly.
  - DONE at 176 cycles; RDATA unchanged.
- REQ pulsed mid-transaction with different ADDR:
  - Ignored; bus bits unchanged.
  - Subsequent REQ after DONE accepted normally and clears ACK_ERR.
- RSTN low during the RD bit 3 slot:
  - Next cycle SCL=1, SDA_OE=0, BUSY=0, RDATA=0.
  - A fresh write transaction then completes correctly.
- CLK_DIV=3, REQ held high:
  - Back-to-back transactions, second accepted the cycle after DONE.
  - SCL period of 12 cycles verified.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// SCL is derived from four divided quarters per bit slot; SDA is driven open-drain through o_sda_oe.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_req,
    input  logic       i_rw,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_wdata,
    input  logic       i_sda_in,
    output logic       o_scl,
    output logic       o_sda_oe,
    output logic [7:0] o_rdata,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic [3:0] o_state
);

    // Host handshake: i_req is sampled only in IDLE; o_busy rises on acceptance and
    // falls together with the one-cycle o_done pulse. Requests while busy are dropped.
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_MACK, S_STOP
    } state_t;

    state_t     r_state, w_state_next;
    logic [7:0] r_div;
    logic [1:0] r_qtr;
    logic [2:0] r_bit;
    logic       r_rw;
    logic [6:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_shift;
    logic [7:0] r_rdata;
    logic       r_busy;
    logic       r_done;
    logic       r_ack_err;
    logic [1:0] r_sync;

    logic       w_tick;
    logic       w_sample;
    logic       w_slot_end;
    logic       w_sda_s;
    logic [7:0] w_addr_byte;

    assign w_tick      = (r_state != S_IDLE) && (r_div == 8'(CLK_DIV - 1));
    assign w_sample    = w_tick && (r_qtr == 2'd2);
    assign w_slot_end  = w_tick && (r_qtr == 2'd3);
    assign w_sda_s     = r_sync[1];
    assign w_addr_byte = {r_addr, r_rw};

    always_comb begin
        w_state_next = r_state;
        o_scl        = 1'b1;
        o_sda_oe     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req) w_state_next = S_START;
            end
            S_START: begin
                o_sda_oe = r_qtr[1];
                if (w_slot_end) w_state_next = S_ADDR;
            end
            S_ADDR: begin
                o_scl    = r_qtr[1];
                o_sda_oe = ~w_addr_byte[~r_bit];
                if (w_slot_end && r_bit == 3'd7) w_state_next = S_AACK;
            end
            S_AACK: begin
                o_scl = r_qtr[1];
                // r_ack_err already holds this slot's sample by the time the slot ends
                if (w_slot_end) w_state_next = r_ack_err ? S_STOP : (r_rw ? S_RD : S_WR);
            end
            S_WR: begin
                o_scl    = r_qtr[1];
                o_sda_oe = ~r_wdata[~r_bit];
                if (w_slot_end && r_bit == 3'd7) w_state_next = S_WACK;
            end
            S_WACK: begin
                o_scl = r_qtr[1];
                if (w_slot_end) w_state_next = S_STOP;
            end
            S_RD: begin
                o_scl = r_qtr[1];
                if (w_slot_end && r_bit == 3'd7) w_state_next = S_MACK;
            end
            S_MACK: begin
                o_scl = r_qtr[1];
                if (w_slot_end) w_state_next = S_STOP;
            end
            S_STOP: begin
                o_scl    = r_qtr[1];
                o_sda_oe = (r_qtr != 2'd3);
                if (w_slot_end) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state   <= S_IDLE;
            r_div     <= 8'd0;
            r_qtr     <= 2'd0;
            r_bit     <= 3'd0;
            r_rw      <= 1'b0;
            r_addr    <= 7'd0;
            r_wdata   <= 8'd0;
            r_shift   <= 8'd0;
            r_rdata   <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_sync    <= 2'b11;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            r_sync  <= {r_sync[0], i_sda_in};
            if (r_state == S_IDLE) begin
                r_div <= 8'd0;
                r_qtr <= 2'd0;
                r_bit <= 3'd0;
                if (i_req) begin
                    r_rw      <= i_rw;
                    r_addr    <= i_addr;
                    r_wdata   <= i_wdata;
                    r_busy    <= 1'b1;
                    r_ack_err <= 1'b0;
                end
            end else begin
                if (w_tick) begin
                    r_div <= 8'd0;
                    r_qtr <= r_qtr + 2'd1;
                end else begin
                    r_div <= r_div + 8'd1;
                end
                // Bit counter wraps 7->0 on its own at the end of each byte
                if (w_slot_end) begin
                    if (r_state == S_ADDR || r_state == S_WR || r_state == S_RD)
                        r_bit <= r_bit + 3'd1;
                    else
                        r_bit <= 3'd0;
                end
                if (w_sample) begin
                    if ((r_state == S_AACK || r_state == S_WACK) && w_sda_s)
                        r_ack_err <= 1'b1;
                    if (r_state == S_RD)
                        r_shift <= {r_shift[6:0], w_sda_s};
                end
                if (w_slot_end && r_state == S_MACK)
                    r_rdata <= r_shift;
                if (w_slot_end && r_state == S_STOP) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign o_rdata   = r_rdata;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_ack_err = r_ack_err;
    assign o_state   = r_state;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: a bus-decoding slave model on a CLK_DIV=4 instance
// and a second CLK_DIV=3 instance for back-to-back and SCL period checks.
module tb_i2c_master_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic       scl, sda_oe, busy, done, ack_err;
    logic [7:0] rdata;
    logic [3:0] state;
    logic       bus_sda;

    logic       req3 = 1'b0;
    logic       scl3, sda_oe3, busy3, done3, ack_err3;
    logic [7:0] rdata3;
    logic [3:0] state3;

    int checks = 0;
    int errors = 0;

    // slave model configuration (written by the stimulus) and observations (written by the model)
    logic       slave_ack_en = 1'b1;
    logic [7:0] slave_rd_byte = 8'hA5;
    logic       sl_sda, prev_scl, prev_sda, sl_rw, scl_now, sda_now;
    logic [7:0] sl_shift, byte0, byte1;
    logic       ack0, ack1;
    int         sl_bits, sl_nbytes, starts, stops;

    always #5 clk = ~clk;

    assign bus_sda = ~sda_oe & sl_sda;

    i2c_master_ctrl #(.CLK_DIV(4)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_rw(rw), .i_addr(addr),
        .i_wdata(wdata), .i_sda_in(bus_sda), .o_scl(scl), .o_sda_oe(sda_oe),
        .o_rdata(rdata), .o_busy(busy), .o_done(done), .o_ack_err(ack_err),
        .o_state(state)
    );

    i2c_master_ctrl #(.CLK_DIV(3)) dut3 (
        .i_clk(clk), .i_rstn(rstn), .i_req(req3), .i_rw(1'b0), .i_addr(7'h15),
        .i_wdata(8'h3C), .i_sda_in(1'b0), .o_scl(scl3), .o_sda_oe(sda_oe3),
        .o_rdata(rdata3), .o_busy(busy3), .o_done(done3), .o_ack_err(ack_err3),
        .o_state(state3)
    );

    // Slave: decodes START/STOP and bits on SCL rise, changes SDA only after SCL falls
    always @(negedge clk) begin
        scl_now = scl;
        sda_now = bus_sda;
        if (!rstn) begin
            sl_sda = 1'b1; prev_scl = 1'b1; prev_sda = 1'b1; sl_rw = 1'b0;
            sl_bits = 0; sl_nbytes = 0; starts = 0; stops = 0;
            sl_shift = 8'd0; byte0 = 8'd0; byte1 = 8'd0; ack0 = 1'b1; ack1 = 1'b1;
        end else begin
            if (prev_scl && scl_now && prev_sda && !sda_now) begin
                starts++; sl_bits = 0; sl_nbytes = 0; sl_sda = 1'b1; ack0 = 1'b1;
            end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
                stops++;
            end else if (!prev_scl && scl_now) begin
                if (sl_bits < 8) begin
                    sl_shift = {sl_shift[6:0], sda_now};
                    sl_bits++;
                end else begin
                    if (sl_nbytes == 0) begin byte0 = sl_shift; ack0 = sda_now; end
                    else begin byte1 = sl_shift; ack1 = sda_now; end
                    sl_nbytes++;
                    sl_bits = 0;
                end
            end else if (prev_scl && !scl_now) begin
                sl_sda = 1'b1;
                if (sl_bits == 8) begin
                    if (sl_nbytes == 0) begin
                        sl_rw  = sl_shift[0];
                        sl_sda = ~slave_ack_en;
                    end else if (sl_nbytes == 1 && !sl_rw) begin
                        sl_sda = 1'b0;
                    end
                end else if (sl_nbytes == 1 && sl_rw && !ack0) begin
                    sl_sda = slave_rd_byte[3'(7 - sl_bits)];
                end
            end
            prev_scl = scl_now;
            prev_sda = sda_now;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_txn(input logic t_rw, input logic [6:0] t_addr, input logic [7:0] t_wdata);
        @(negedge clk);
        req = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata;
        @(posedge clk); #1;
        req = 1'b0;
        chk("accept_busy", {31'd0, busy}, 32'd1);
    endtask

    // Counts cycles from the acceptance edge until DONE; optionally pulses a bogus REQ
    task automatic wait_done(input int pulse_at, output int lat);
        lat = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == pulse_at) begin req = 1'b1; addr = 7'h11; rw = 1'b1; end
            else req = 1'b0;
            if (done) break;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    int lat, stops0, n;
    int rise[3];
    int nrise;
    logic prev3;

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", {31'd0, scl}, 32'd1);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        rstn = 1'b1;

        // write 0x2A / 0x5C
        stops0 = stops;
        start_txn(1'b0, 7'h2A, 8'h5C);
        wait_done(0, lat);
        chk("wr_latency", lat, 320);
        chk("wr_ack_err", {31'd0, ack_err}, 32'd0);
        chk("wr_addr_byte", {24'd0, byte0}, 32'h54);
        chk("wr_data_byte", {24'd0, byte1}, 32'h5C);
        chk("wr_addr_ack", {31'd0, ack0}, 32'd0);
        chk("wr_data_ack", {31'd0, ack1}, 32'd0);
        chk("wr_nbytes", sl_nbytes, 2);
        chk("wr_stop", stops - stops0, 1);
        @(posedge clk); #1;
        chk("wr_busy_after", {31'd0, busy}, 32'd0);
        chk("wr_done_pulse", {31'd0, done}, 32'd0);

        // read 0x2A, slave returns 0xA5
        start_txn(1'b1, 7'h2A, 8'h00);
        wait_done(0, lat);
        chk("rd_latency", lat, 320);
        chk("rd_addr_byte", {24'd0, byte0}, 32'h55);
        chk("rd_master_nack", {31'd0, ack1}, 32'd1);
        chk("rd_rdata", {24'd0, rdata}, 32'hA5);
        chk("rd_ack_err", {31'd0, ack_err}, 32'd0);

        // address NACK on a read: RDATA must not change
        slave_ack_en = 1'b0;
        slave_rd_byte = 8'h3E;
        stops0 = stops;
        start_txn(1'b1, 7'h2A, 8'h00);
        wait_done(0, lat);
        chk("nack_latency", lat, 176);
        chk("nack_ack_err", {31'd0, ack_err}, 32'd1);
        chk("nack_rdata", {24'd0, rdata}, 32'hA5);
        chk("nack_nbytes", sl_nbytes, 1);
        chk("nack_stop", stops - stops0, 1);
        slave_ack_en = 1'b1;
        slave_rd_byte = 8'hA5;

        // REQ pulsed mid-transaction with a different address is ignored
        start_txn(1'b0, 7'h2A, 8'h33);
        chk("req_clears_ack_err", {31'd0, ack_err}, 32'd0);
        wait_done(100, lat);
        chk("pulse_latency", lat, 320);
        chk("pulse_addr_byte", {24'd0, byte0}, 32'h54);
        chk("pulse_data_byte", {24'd0, byte1}, 32'h33);
        chk("pulse_ack_err", {31'd0, ack_err}, 32'd0);
        @(posedge clk); #1;
        chk("pulse_idle", {31'd0, busy}, 32'd0);

        // reset during RD bit 3 (quarters 52..55 = cycles 209..224 after acceptance)
        start_txn(1'b1, 7'h2A, 8'h00);
        repeat (214) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_scl", {31'd0, scl}, 32'd1);
        chk("mid_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rdata", {24'd0, rdata}, 32'd0);
        rstn = 1'b1;
        start_txn(1'b0, 7'h2A, 8'h5C);
        wait_done(0, lat);
        chk("post_rst_latency", lat, 320);
        chk("post_rst_addr_byte", {24'd0, byte0}, 32'h54);
        chk("post_rst_data_byte", {24'd0, byte1}, 32'h5C);
        chk("post_rst_ack_err", {31'd0, ack_err}, 32'd0);

        // CLK_DIV=3, REQ held high: back-to-back transactions
        @(negedge clk);
        req3 = 1'b1;
        @(posedge clk); #1;
        chk("d3_accept", {31'd0, busy3}, 32'd1);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            n++;
            if (done3) break;
        end
        chk("d3_latency1", n, 240);
        @(posedge clk); #1;
        chk("d3_b2b_accept", {31'd0, busy3}, 32'd1);
        chk("d3_done_clear", {31'd0, done3}, 32'd0);
        n = 0;
        nrise = 0;
        prev3 = scl3;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            n++;
            if (!prev3 && scl3 && nrise < 3) begin
                rise[nrise] = n;
                nrise++;
            end
            prev3 = scl3;
            if (done3) begin
                req3 = 1'b0;
                break;
            end
        end
        req3 = 1'b0;
        chk("d3_latency2", n, 240);
        chk("d3_nrise", nrise, 3);
        chk("d3_first_rise", rise[0], 18);
        chk("d3_scl_period_a", rise[1] - rise[0], 12);
        chk("d3_scl_period_b", rise[2] - rise[1], 12);
        chk("d3_ack_err", {31'd0, ack_err3}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
